// File: rtl/gb_timer.sv
// gb_timer: DMG DIV/TIMA/TMA/TAC timer at $FF04-$FF07.
// TIMA counts falling edges of the selected sys_cnt bit. Overflow reloads TMA after OVF_DELAY clks.
//
// Ports:
//   clk            4.194304 MHz system clock
//   rst            synchronous, active-high reset
//   ADDR           CPU address
//   WR             write strobe (level; repeats are idempotent)
//   RD             read strobe (unused; reads decode on ADDR only)
//   MMIO_DATA_out  write data from the MMU
//   MMIO_DATA_in   read data to the MMU (8'hFF when ADDR misses)
//   IRQ_TIMER      one-clk interrupt pulse, registered
module gb_timer #(
   parameter logic [15:0] DIV_INIT  = 16'h0000,
   parameter int unsigned OVF_DELAY = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ADDR,
   input  logic        WR,
   input  logic        RD,
   input  logic [7:0]  MMIO_DATA_out,
   output logic [7:0]  MMIO_DATA_in,
   output logic        IRQ_TIMER
);

   localparam logic [2:0] CNT_LAST = 3'(OVF_DELAY - 1);

   logic [15:0] sys_cnt_q, sys_cnt_d;
   logic [7:0]  tima_q, tima_d;
   logic [7:0]  tma_q, tma_d;
   logic [2:0]  tac_q, tac_d;
   logic        prev_tick_q;
   logic        pend_q, pend_d;
   logic [2:0]  cnt_q, cnt_d;
   logic        reload_q, reload_d;
   logic        irq_q, irq_d;

   logic hit_div, hit_tima, hit_tma, hit_tac;
   logic wr_div, wr_tima, wr_tma, wr_tac;
   logic sel_bit, tick, fall, reload_due;
   logic unused_rd;

   assign unused_rd = RD;

   assign hit_div  = (ADDR == 16'hFF04);
   assign hit_tima = (ADDR == 16'hFF05);
   assign hit_tma  = (ADDR == 16'hFF06);
   assign hit_tac  = (ADDR == 16'hFF07);

   assign wr_div  = WR & hit_div;
   assign wr_tima = WR & hit_tima;
   assign wr_tma  = WR & hit_tma;
   assign wr_tac  = WR & hit_tac;

   always_comb begin
      unique case (tac_q[1:0])
         2'b00: sel_bit = sys_cnt_q[9];
         2'b01: sel_bit = sys_cnt_q[3];
         2'b10: sel_bit = sys_cnt_q[5];
         2'b11: sel_bit = sys_cnt_q[7];
      endcase
   end

   // DIV clears and TAC changes pull tick low too, so they count as edges.
   assign tick       = sel_bit & tac_q[2];
   assign fall       = prev_tick_q & ~tick;
   assign reload_due = pend_q && (cnt_q == CNT_LAST);

   always_comb begin
      MMIO_DATA_in = 8'hFF;
      unique case (1'b1)
         hit_div:  MMIO_DATA_in = sys_cnt_q[15:8];
         hit_tima: MMIO_DATA_in = tima_q;
         hit_tma:  MMIO_DATA_in = tma_q;
         hit_tac:  MMIO_DATA_in = {5'b11111, tac_q};
         default:  MMIO_DATA_in = 8'hFF;
      endcase
   end

   always_comb begin
      sys_cnt_d = wr_div ? 16'h0000 : sys_cnt_q + 16'd1;
      tma_d     = wr_tma ? MMIO_DATA_out : tma_q;
      tac_d     = wr_tac ? MMIO_DATA_out[2:0] : tac_q;
      tima_d    = tima_q;
      pend_d    = pend_q;
      cnt_d     = pend_q ? cnt_q + 3'd1 : cnt_q;
      reload_d  = 1'b0;
      irq_d     = 1'b0;

      // A CPU write beats both the reload and the increment,
      // except in the reload cycle where the TMA value is kept.
      if (wr_tima && !reload_q) begin
         tima_d = MMIO_DATA_out;
         pend_d = 1'b0;
         cnt_d  = 3'd0;
      end else if (reload_due) begin
         tima_d   = tma_q;
         pend_d   = 1'b0;
         cnt_d    = 3'd0;
         reload_d = 1'b1;
         irq_d    = 1'b1;
      end else if (fall) begin
         tima_d = tima_q + 8'd1;
         if (tima_q == 8'hFF) begin
            pend_d = 1'b1;
            cnt_d  = 3'd0;
         end
      end

      // New TMA written in the reload cycle lands in TIMA as well.
      if (wr_tma && reload_q) begin
         tima_d = MMIO_DATA_out;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sys_cnt_q   <= DIV_INIT;
         tima_q      <= 8'h00;
         tma_q       <= 8'h00;
         tac_q       <= 3'b000;
         prev_tick_q <= 1'b0;
         pend_q      <= 1'b0;
         cnt_q       <= 3'd0;
         reload_q    <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         sys_cnt_q   <= sys_cnt_d;
         tima_q      <= tima_d;
         tma_q       <= tma_d;
         tac_q       <= tac_d;
         prev_tick_q <= tick;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         reload_q    <= reload_d;
         irq_q       <= irq_d;
      end
   end

   assign IRQ_TIMER = irq_q;

endmodule

// File: tb/tb_gb_timer.sv
// tb_gb_timer: directed bench for gb_timer.
// Hand-computed vectors for DIV, TIMA counting, overflow delay and edge cases.
module tb_gb_timer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ADDR = 16'h0000;
   logic        WR = 1'b0;
   logic        RD = 1'b0;
   logic [7:0]  dout = 8'h00;
   logic [7:0]  din;
   logic        irq;

   int n_chk = 0;
   int n_fail = 0;
   int irq_seen = 0;
   int base;

   gb_timer dut (
      .clk           (clk),
      .rst           (rst),
      .ADDR          (ADDR),
      .WR            (WR),
      .RD            (RD),
      .MMIO_DATA_out (dout),
      .MMIO_DATA_in  (din),
      .IRQ_TIMER     (irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (irq) irq_seen++;
   end

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      ADDR = a;
      dout = d;
      WR   = 1'b1;
      @(posedge clk);
      #1;
      WR   = 1'b0;
      ADDR = 16'h0000;
   endtask

   task automatic chk_rd(input string tag, input logic [15:0] a,
                         input logic [7:0] exp);
      logic [7:0] v;
      ADDR = a;
      RD   = 1'b1;
      #1;
      v    = din;
      RD   = 1'b0;
      chk(tag, v, exp);
   endtask

   task automatic do_rst;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // After this: TIMA=tima, TMA=tma, TAC=101, edges counted from DIV write.
   // Next TIMA increment lands 14 edges after return.
   task automatic ovf_setup(input logic [7:0] tma, input logic [7:0] tima);
      do_rst;
      wr(16'hFF04, 8'h00);
      wr(16'hFF06, tma);
      wr(16'hFF05, tima);
      wr(16'hFF07, 8'h05);
   endtask

   initial begin
      // reset state and DIV
      do_rst;
      chk_rd("rst_div", 16'hFF04, 8'h00);
      chk_rd("rst_tima", 16'hFF05, 8'h00);
      chk_rd("rst_tma", 16'hFF06, 8'h00);
      chk_rd("rst_tac", 16'hFF07, 8'hF8);
      chk("rst_irq", {7'd0, irq}, 8'h00);
      cyc(255);
      chk_rd("div_255", 16'hFF04, 8'h00);
      cyc(1);
      chk_rd("div_256", 16'hFF04, 8'h01);
      cyc(65280);
      chk_rd("div_wrap", 16'hFF04, 8'h00);
      chk_rd("tima_idle", 16'hFF05, 8'h00);

      // counting at 16 clk per tick
      do_rst;
      wr(16'hFF04, 8'h00);
      wr(16'hFF05, 8'h00);
      wr(16'hFF07, 8'h05);
      cyc(158);
      chk_rd("cnt_9", 16'hFF05, 8'h09);
      cyc(1);
      chk_rd("cnt_10", 16'hFF05, 8'h0A);

      // overflow with delayed reload
      ovf_setup(8'h42, 8'hFF);
      cyc(13);
      base = irq_seen;
      chk_rd("ovf_pre", 16'hFF05, 8'hFF);
      cyc(1);
      chk_rd("ovf_0", 16'hFF05, 8'h00);
      chk("ovf_irq0", {7'd0, irq}, 8'h00);
      cyc(3);
      chk_rd("ovf_3", 16'hFF05, 8'h00);
      chk("ovf_irq3", {7'd0, irq}, 8'h00);
      cyc(1);
      chk_rd("ovf_reload", 16'hFF05, 8'h42);
      chk("ovf_irq", {7'd0, irq}, 8'h01);
      cyc(1);
      chk("ovf_irq_off", {7'd0, irq}, 8'h00);
      chk_rd("ovf_hold", 16'hFF05, 8'h42);
      cyc(3);
      chk("ovf_pulses", 8'(irq_seen - base), 8'h01);

      // TIMA write in the delay window cancels reload/IRQ
      ovf_setup(8'h42, 8'hFF);
      cyc(14);
      base = irq_seen;
      wr(16'hFF05, 8'h10);
      chk_rd("cancel_tima", 16'hFF05, 8'h10);
      cyc(8);
      chk_rd("cancel_hold", 16'hFF05, 8'h10);
      chk("cancel_irq", 8'(irq_seen - base), 8'h00);

      // TIMA write in the reload cycle is ignored
      ovf_setup(8'h42, 8'hFF);
      cyc(18);
      wr(16'hFF05, 8'h77);
      chk_rd("rl_tima_wr", 16'hFF05, 8'h42);

      // TMA write in the reload cycle also loads TIMA
      ovf_setup(8'h42, 8'hFF);
      cyc(18);
      wr(16'hFF06, 8'h55);
      chk_rd("rl_tma_tima", 16'hFF05, 8'h55);
      chk_rd("rl_tma_tma", 16'hFF06, 8'h55);

      // DIV write and TAC disable as falling edges
      do_rst;
      wr(16'hFF04, 8'h00);
      wr(16'hFF07, 8'h04);
      cyc(599);
      chk_rd("b9_pre", 16'hFF05, 8'h00);
      wr(16'hFF04, 8'h5A);
      cyc(1);
      chk_rd("div_fall", 16'hFF05, 8'h01);
      cyc(520);
      chk_rd("div_once", 16'hFF05, 8'h01);
      wr(16'hFF07, 8'h00);
      cyc(1);
      chk_rd("tac_fall", 16'hFF05, 8'h02);
      cyc(10);
      chk_rd("tac_once", 16'hFF05, 8'h02);

      // TAC readback and unmapped address
      do_rst;
      wr(16'hFF07, 8'hFF);
      chk_rd("tac_ff", 16'hFF07, 8'hFF);
      wr(16'hFF07, 8'h00);
      chk_rd("tac_00", 16'hFF07, 8'hF8);
      chk_rd("unmapped", 16'hFF08, 8'hFF);
      chk_rd("unmapped_lo", 16'hFF03, 8'hFF);

      // reset during the delay window
      ovf_setup(8'h42, 8'hFF);
      cyc(15);
      base = irq_seen;
      do_rst;
      chk_rd("mid_tima", 16'hFF05, 8'h00);
      chk_rd("mid_tma", 16'hFF06, 8'h00);
      chk_rd("mid_tac", 16'hFF07, 8'hF8);
      chk_rd("mid_div", 16'hFF04, 8'h00);
      cyc(8);
      chk("mid_irq", 8'(irq_seen - base), 8'h00);
      chk_rd("mid_tima2", 16'hFF05, 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
